// File: rtl/alu_pkg.sv
// Purpose: shared constants for the 8-bit ALU (op groups, operand select, BCD limits).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  // op[4:2] group encodings
  localparam logic [2:0] GRP_OR     = 3'b000;
  localparam logic [2:0] GRP_AND    = 3'b001;
  localparam logic [2:0] GRP_EOR    = 3'b010;
  localparam logic [2:0] GRP_ADD    = 3'b011;
  localparam logic [2:0] GRP_SUB    = 3'b100;
  localparam logic [2:0] GRP_SHL    = 3'b101;
  localparam logic [2:0] GRP_SHR    = 3'b110;
  localparam logic [2:0] GRP_INCDEC = 3'b111;

  // op bit choosing M (1) or R (0) as the single operand of shift/incdec groups
  localparam int OPSEL_BIT = 0;

  // BCD decimal-adjust limits: low digit and packed two-digit result
  localparam logic [3:0] BCD_LO_LIMIT = 4'h9;
  localparam logic [8:0] BCD_HI_LIMIT = 9'h099;

endpackage

// File: rtl/alu_adder.sv
// Purpose: 8-bit adder with carry in; gives carry out, signed overflow and (BCD build) nibble carry.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module alu_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co,
`ifdef ALU_BCD_EN
  output logic       hc,
`endif
  output logic       v
);

  // 9-bit sum; overflow when both inputs share a sign that the result does not
  always_comb begin
    {co, sum} = {1'b0, a} + {1'b0, b} + {8'b0, ci};
    v         = (a[7] == b[7]) && (sum[7] != a[7]);
  end

`ifdef ALU_BCD_EN
  // Carry out of bit 3 recovered from the bit-4 sum: a^b^sum gives the carry into that bit
  assign hc = a[4] ^ b[4] ^ sum[4];
`endif

endmodule

// File: rtl/alu.sv
// Purpose: 8-bit ALU (logic, add/sub, shifts, pass/inc/dec) with BCD adjust flags when ALU_BCD_EN is defined.
// Latency: all results combinational; CO_1 is CO delayed by one clk.
// Backpressure: none; new operands are accepted every cycle.
module alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       CI,
  input  logic       SI,
  input  logic [7:0] R,
  input  logic [7:0] M,
  input  logic [4:0] op,
  output logic [7:0] OUT,
  output logic       CO,
  output logic       V,
  output logic       adjh,
  output logic       adjl,
  output logic       CO_1
);

  logic [2:0] grp;
  logic [7:0] x_opd;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_co;
  logic       add_v;
`ifdef ALU_BCD_EN
  logic       add_hc;
`endif

  assign grp   = op[4:2];
  assign x_opd = op[OPSEL_BIT] ? M : R;

  // Steer the shared adder: R+M for ADD, R+~M for SUB, X+{00|FF} for pass/inc/dec
  always_comb begin
    add_a = R;
    add_b = M;
    case (grp)
      GRP_SUB:    add_b = ~M;
      GRP_INCDEC: begin
        add_a = x_opd;
        add_b = op[1] ? 8'hFF : 8'h00;
      end
      default: ;
    endcase
  end

  alu_adder u_adder (
    .a   (add_a),
    .b   (add_b),
    .ci  (CI),
    .sum (add_sum),
    .co  (add_co),
`ifdef ALU_BCD_EN
    .hc  (add_hc),
`endif
    .v   (add_v)
  );

  // Result, carry and overflow selection per op group
  always_comb begin
    OUT = R | M;
    CO  = 1'b0;
    V   = 1'b0;
    case (grp)
      GRP_OR:  OUT = R | M;
      GRP_AND: OUT = R & M;
      GRP_EOR: OUT = R ^ M;
      GRP_ADD, GRP_SUB: begin
        OUT = add_sum;
        CO  = add_co;
        V   = add_v;
      end
      GRP_SHL: begin
        OUT = {x_opd[6:0], SI};
        CO  = x_opd[7];
      end
      GRP_SHR: begin
        OUT = {SI, x_opd[7:1]};
        CO  = x_opd[0];
      end
      GRP_INCDEC: begin
        OUT = add_sum;
        CO  = add_co;
      end
      default: ;
    endcase
  end

`ifdef ALU_BCD_EN
  // Decimal adjust requests: after ADD test the digits against 9/0x99, after SUB use the borrows
  always_comb begin
    adjl = 1'b0;
    adjh = 1'b0;
    case (grp)
      GRP_ADD: begin
        adjl = add_hc | (OUT[3:0] > BCD_LO_LIMIT);
        adjh = CO | ({CO, OUT} > BCD_HI_LIMIT);
      end
      GRP_SUB: begin
        adjl = ~add_hc;
        adjh = ~CO;
      end
      default: ;
    endcase
  end
`else
  assign adjl = 1'b0;
  assign adjh = 1'b0;
`endif

  // Delayed carry; reset clears it asynchronously
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) CO_1 <= 1'b0;
    else      CO_1 <= CO;
  end

endmodule

// File: tb/tb_alu.sv
// Purpose: scoreboard bench for alu using hand-computed directed vectors.
// Latency: vectors driven 1 time unit after posedge, checked at the following negedge.
// Backpressure: none; one vector per clock.
module tb_alu;

  logic       clk = 1'b0;
  logic       RST;
  logic       CI;
  logic       SI;
  logic [7:0] R;
  logic [7:0] M;
  logic [4:0] op;
  logic [7:0] OUT;
  logic       CO;
  logic       V;
  logic       adjh;
  logic       adjl;
  logic       CO_1;

  int total = 0;
  int bad   = 0;
  int vec_n = 0;

`ifdef ALU_BCD_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  typedef struct {
    int         idx;
    logic [7:0] out;
    logic       co;
    logic       v;
    logic       adjl;
    logic       adjh;
    logic       co1;
  } exp_t;

  exp_t exp_q[$];
  logic prev_co   = 1'b0;
  logic co1_model = 1'b0;

  alu dut (
    .clk  (clk),
    .RST  (RST),
    .CI   (CI),
    .SI   (SI),
    .R    (R),
    .M    (M),
    .op   (op),
    .OUT  (OUT),
    .CO   (CO),
    .V    (V),
    .adjh (adjh),
    .adjl (adjl),
    .CO_1 (CO_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drive one vector after the posedge and queue its expected response.
  task automatic apply(input logic [4:0] o, input logic [7:0] r, input logic [7:0] m,
                       input logic ci, input logic si, input logic [7:0] e_out,
                       input logic e_co, input logic e_v, input logic e_adjl, input logic e_adjh);
    exp_t e;
    @(posedge clk);
    co1_model = RST ? prev_co : 1'b0;
    #1;
    op = o; R = r; M = m; CI = ci; SI = si;
    e.idx  = vec_n;
    e.out  = e_out;
    e.co   = e_co;
    e.v    = e_v;
    e.adjl = BCD_EN ? e_adjl : 1'b0;
    e.adjh = BCD_EN ? e_adjh : 1'b0;
    e.co1  = co1_model;
    exp_q.push_back(e);
    prev_co = e_co;
    vec_n++;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d OUT", e.idx),  OUT,         e.out);
        check($sformatf("v%0d CO", e.idx),   {7'b0, CO},  {7'b0, e.co});
        check($sformatf("v%0d V", e.idx),    {7'b0, V},   {7'b0, e.v});
        check($sformatf("v%0d adjl", e.idx), {7'b0, adjl}, {7'b0, e.adjl});
        check($sformatf("v%0d adjh", e.idx), {7'b0, adjh}, {7'b0, e.adjh});
        check($sformatf("v%0d CO_1", e.idx), {7'b0, CO_1}, {7'b0, e.co1});
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0; CI = 1'b0; SI = 1'b0; R = 8'h00; M = 8'h00; op = 5'b00000;
    repeat (3) @(posedge clk);
    #2;
    check("reset CO_1", {7'b0, CO_1}, 8'h00);
    @(negedge clk);
    RST = 1'b1;

    //     op        R      M      CI    SI    OUT    CO    V     adjl  adjh
    apply(5'b00000, 8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0); // OR
    apply(5'b00100, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0); // AND, low op bits swept
    apply(5'b00101, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(5'b00110, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(5'b00111, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(5'b01000, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0); // EOR
    apply(5'b01100, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1); // ADD overflow
    apply(5'b01100, 8'h19, 8'h28, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0); // ADD half carry
    apply(5'b01101, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1); // ADD carry out
    apply(5'b01100, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1); // ADD neg overflow
    apply(5'b01100, 8'h45, 8'h54, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0); // ADD at BCD limits
    apply(5'b01100, 8'h45, 8'h55, 1'b0, 1'b0, 8'h9A, 1'b0, 1'b1, 1'b1, 1'b1); // ADD past BCD limits
    apply(5'b01100, 8'h05, 8'h04, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0); // ADD low digit = 9
    apply(5'b10000, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1); // SUB borrow
    apply(5'b10011, 8'h50, 8'h20, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0); // SUB no borrow
    apply(5'b10000, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0); // SUB overflow
    apply(5'b10100, 8'h55, 8'hFF, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0); // SHL R
    apply(5'b10110, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0); // SHL R, op[1] ignored
    apply(5'b11000, 8'h01, 8'h00, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0); // SHR R
    apply(5'b11011, 8'hFF, 8'h02, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0); // SHR M
    apply(5'b11110, 8'h00, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0); // R+FF
    apply(5'b11100, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); // R+CI
    apply(5'b11101, 8'h00, 8'h7F, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0); // M+CI, V stays 0
    apply(5'b11111, 8'hAA, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); // M+FF+CI
    apply(5'b10101, 8'h00, 8'h80, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0); // SHL M, CO=1
    apply(5'b00000, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); // CO_1 now 1

    // Reset between edges clears CO_1 immediately
    @(negedge clk);
    #2;
    RST = 1'b0;
    #1;
    check("async reset CO_1", {7'b0, CO_1}, 8'h00);

    // Combinational outputs keep working while in reset; CO_1 held at 0
    apply(5'b01100, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    RST = 1'b1;
    // First edge after release loads the carry of the vector above
    apply(5'b11100, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(5'b00001, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; the datapath is fixed at 8 bits.
REQ-002 clk  input  1  single clock; the only registered element (CO_1) updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low (RST=0 resets).
REQ-004 CI  input  1  carry in.
REQ-005 SI  input  1  shift in.
REQ-006 R  input  8  register-file operand.
REQ-007 M  input  8  memory/M-register operand.
REQ-008 op  input  5  operation select.
REQ-009 OUT  output  8  result (combinational).
REQ-010 CO  output  1  carry out (combinational).
REQ-011 V  output  1  signed overflow (combinational).
REQ-012 adjh  output  1  BCD high-nibble adjust request (combinational).
REQ-013 adjl  output  1  BCD low-nibble adjust request (combinational).
REQ-014 CO_1  output  1  CO delayed by one clock (registered).

Function
REQ-015 op[4:2] selects the group; op[1:0] are ignored in groups 000-100.
- 000 OR: OUT=R|M, CO=0.
- 001 AND: OUT=R&M, CO=0.
- 010 EOR: OUT=R^M, CO=0.
- 011 ADD: {CO,OUT}=R+M+CI, 9-bit.
- 100 SUB: {CO,OUT}=R+~M+CI; CO=1 means no borrow.
REQ-016 Shift groups use operand X, where X=R if op[0]=0 and X=M if op[0]=1; op[1] is ignored.
- 101 shift left: OUT={X[6:0],SI}, CO=X[7].
- 110 shift right: OUT={SI,X[7:1]}, CO=X[0].
REQ-017 Group 111 (pass/increment/decrement), with 9-bit carry into CO:
- op[1:0]=00: R+CI.
- op[1:0]=01: M+CI.
- op[1:0]=10: R+0xFF+CI.
- op[1:0]=11: M+0xFF+CI.
REQ-018 V is asserted only in ADD and SUB: V=1 when both adder inputs have the same bit 7 and OUT[7] differs from it; V=0 in all other groups.
REQ-019 hc is the carry out of bit 3 of the active adder (adder input low nibbles plus CI).
REQ-020 ADD adjust flags:
- adjl = hc | (OUT[3:0] > 9).
- adjh = CO | ({CO,OUT} > 0x99).
REQ-021 SUB adjust flags: adjl=~hc, adjh=~CO.
REQ-022 adjl=adjh=0 in every group other than ADD and SUB.
REQ-023 Outputs other than CO_1 are purely combinational (zero latency) and independent of clk and RST.
REQ-024 CO_1 loads CO on every rising clk edge while RST=1.

Reset
REQ-025 RST=0 forces CO_1=0 immediately, independent of clk; this includes reset asserted mid-operation.
REQ-026 The first rising edge after RST returns to 1 loads CO into CO_1.
REQ-027 Reset has no effect on the combinational outputs.

Configuration
REQ-028 Macro ALU_BCD_EN controls the BCD adjust logic.
- Defined: adjh and adjl behave per REQ-020 to REQ-022.
- Undefined: adjh and adjl are tied to 0 and the comparator logic is absent.
- All other behaviour is identical in both builds.

Structure
REQ-029 A shared package alu_pkg holds:
- the op group encodings (OR, AND, EOR, ADD, SUB, SHL, SHR, INCDEC) as named 3-bit constants;
- the operand-select bit position;
- the BCD limit constants 9 and 0x99.
REQ-030 One sub-module, alu_adder, is natural: 8-bit adder with CI, CO, hc and V outputs, shared by ADD, SUB and group 111.

Verification
REQ-031 ADD, R=0x50, M=0x50, CI=0 -> OUT=0xA0, CO=0, V=1, adjl=0, adjh=1.
REQ-032 SUB, R=0x00, M=0x01, CI=1 -> OUT=0xFF, CO=0, V=0, adjl=1, adjh=1.
REQ-033 ADD, R=0x19, M=0x28, CI=0 -> OUT=0x41, CO=0, adjl=1, adjh=0; same stimulus built without ALU_BCD_EN -> adjl=adjh=0.
REQ-034 Shift left with op[0]=1, M=0x80, SI=1 -> OUT=0x01, CO=1; after the next clk edge CO_1=1; then drive RST=0 between edges -> CO_1=0 at once.
REQ-035 Group 111 op[1:0]=10, R=0x00, CI=0 -> OUT=0xFF, CO=0; op[1:0]=00, R=0xFF, CI=1 -> OUT=0x00, CO=1.
REQ-036 AND, R=0xF0, M=0x3C, op[1:0] swept over all four values -> OUT=0x30, CO=0, V=0 in every case.
